felica_deframer: RTL and testbench

FELICA_DEFRAMER -- requirements
Module: felica_deframer

---
 rtl/felica_pkg.sv | 24 ++
 rtl/felica_crc16.sv | 29 ++
 rtl/felica_deframer.sv | 240 ++++++++++++++++++++++++
 tb/tb_felica_deframer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/felica_pkg.sv
// FeliCa deframer shared definitions: FSM state type, default sync word and
// the CRC-16/CCITT constants plus a single-bit CRC update helper.
package felica_pkg;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC  = 3'd3,
    ST_DONE = 3'd4
  } felica_state_e;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hB24D;
  localparam logic [15:0] CRC_POLY          = 16'h1021;
  localparam logic [15:0] CRC_INIT          = 16'h0000;

  // One MSB-first CRC-16/CCITT step (no reflection, no final XOR).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/felica_crc16.sv
// Bit-serial CRC-16/CCITT engine (poly 0x1021, init 0x0000). Updates on the
// falling clock edge to stay aligned with the deframer's state changes.
module felica_crc16
  import felica_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        bit_en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // CRC register: clear has priority over a bit update.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= CRC_INIT;
    end else if (clr) begin
      crc_r <= CRC_INIT;
    end else if (bit_en) begin
      crc_r <= crc16_step(crc_r, bit_in);
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/felica_deframer.sv
// FeliCa frame deframer: hunts for preamble + sync, then assembles the LEN,
// payload and two CRC bytes from a decoded Manchester bit stream.
// Optional feature macro: FELICA_DEFRAMER_CRC_CHECK_EN compiles in the CRC
// engine; without it crc_ok simply reports "no abort" at frame_end.
module felica_deframer
  import felica_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int          PRE_MIN   = 16,
  parameter logic [7:0]  MAX_LEN   = 8'd254
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       carrier_lost,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       crc_ok,
  output logic       frame_err
);

  localparam logic [5:0] PRE_MIN_C = 6'(PRE_MIN);

  felica_state_e state_r;
  felica_state_e state_s;

  // Hunt datapath: 15 stored bits plus the incoming bit form the 16-bit
  // window. pre_ok_r remembers, per stored bit, whether the zero run before
  // that bit was long enough, so the check refers to the window's first bit.
  logic [14:0] shift_r;
  logic [14:0] pre_ok_r;
  logic [5:0]  zero_run_r;
  logic [15:0] shift_next_s;

  // Byte assembly and frame bookkeeping.
  logic [2:0]  bit_cnt_r;
  logic [6:0]  byte_sr_r;
  logic [7:0]  rem_r;
  logic        crc_byte_r;

  logic        in_frame_s;
  logic        hunt_bit_s;
  logic        rx_bit_s;
  logic        abort_s;
  logic        sync_hit_s;
  logic        byte_done_s;
  logic [7:0]  byte_s;
  logic        len_bad_s;
  logic        crc_match_s;

  // Next values of the registered outputs.
  logic [7:0]  byte_data_s;
  logic        byte_valid_s;
  logic        frame_start_s;
  logic        frame_end_s;
  logic        crc_ok_s;
  logic        frame_err_s;

  logic [7:0]  byte_data_r;
  logic        byte_valid_r;
  logic        frame_start_r;
  logic        frame_end_r;
  logic        crc_ok_r;
  logic        frame_err_r;

  // carrier_lost always wins over a coincident bit strobe.
  assign in_frame_s   = (state_r == ST_LEN) || (state_r == ST_DATA) || (state_r == ST_CRC);
  assign hunt_bit_s   = (state_r == ST_HUNT) && bit_valid && !carrier_lost;
  assign rx_bit_s     = in_frame_s && bit_valid && !carrier_lost;
  assign abort_s      = in_frame_s && carrier_lost;
  assign shift_next_s = {shift_r, bit_in};
  assign sync_hit_s   = hunt_bit_s && (shift_next_s == SYNC_WORD) && pre_ok_r[14];
  assign byte_s       = {byte_sr_r, bit_in};
  assign byte_done_s  = rx_bit_s && (bit_cnt_r == 3'd7);
  assign len_bad_s    = (byte_s < 8'd2) || (byte_s > MAX_LEN);

`ifdef FELICA_DEFRAMER_CRC_CHECK_EN
  logic [15:0] crc_calc_s;
  logic [14:0] crc_rx_r;
  logic        crc_clr_s;
  logic        crc_en_s;

  // The CRC covers the LEN byte and the payload only.
  assign crc_clr_s = (state_r == ST_HUNT);
  assign crc_en_s  = rx_bit_s && ((state_r == ST_LEN) || (state_r == ST_DATA));

  felica_crc16 u_crc16 (
    .clk    (ck_1356meg),
    .rst_n  (rst_n),
    .clr    (crc_clr_s),
    .bit_en (crc_en_s),
    .bit_in (bit_in),
    .crc    (crc_calc_s)
  );

  // Collect the first 15 received CRC bits; the 16th is compared on the fly.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      crc_rx_r <= 15'd0;
    end else if (state_r == ST_HUNT) begin
      crc_rx_r <= 15'd0;
    end else if (rx_bit_s && (state_r == ST_CRC)) begin
      crc_rx_r <= {crc_rx_r[13:0], bit_in};
    end
  end

  assign crc_match_s = (crc_calc_s == {crc_rx_r, bit_in});
`else
  assign crc_match_s = 1'b1;
`endif

  // FSM state register.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (sync_hit_s) state_s = ST_LEN;
        else            state_s = ST_HUNT;
      end
      ST_LEN: begin
        if (abort_s)          state_s = ST_DONE;
        else if (byte_done_s) state_s = len_bad_s ? ST_DONE : ST_DATA;
        else                  state_s = ST_LEN;
      end
      ST_DATA: begin
        if (abort_s)                             state_s = ST_DONE;
        else if (byte_done_s && (rem_r == 8'd1)) state_s = ST_CRC;
        else                                     state_s = ST_DATA;
      end
      ST_CRC: begin
        if (abort_s)                         state_s = ST_DONE;
        else if (byte_done_s && crc_byte_r)  state_s = ST_DONE;
        else                                 state_s = ST_CRC;
      end
      ST_DONE: state_s = ST_HUNT;
      default: state_s = ST_HUNT;
    endcase
  end

  // FSM output logic: next values of the registered output strobes.
  always_comb begin
    byte_valid_s  = byte_done_s && !((state_r == ST_LEN) && len_bad_s);
    frame_start_s = sync_hit_s;
    frame_end_s   = (state_s == ST_DONE) && (state_r != ST_DONE);
    frame_err_s   = frame_end_s && (abort_s || (state_r == ST_LEN));
    crc_ok_s      = frame_end_s && !frame_err_s && crc_match_s;
    if (byte_valid_s) begin
      byte_data_s = byte_s;
    end else begin
      byte_data_s = byte_data_r;
    end
  end

  // Output registers.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      byte_data_r   <= 8'd0;
      byte_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      crc_ok_r      <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      byte_data_r   <= byte_data_s;
      byte_valid_r  <= byte_valid_s;
      frame_start_r <= frame_start_s;
      frame_end_r   <= frame_end_s;
      crc_ok_r      <= crc_ok_s;
      frame_err_r   <= frame_err_s;
    end
  end

  // Sync hunt: shift window, zero-run counter and per-bit preamble flags.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= 15'd0;
      pre_ok_r   <= 15'd0;
      zero_run_r <= 6'd0;
    end else if (state_r == ST_DONE) begin
      shift_r    <= 15'd0;
      pre_ok_r   <= 15'd0;
      zero_run_r <= 6'd0;
    end else if ((state_r == ST_HUNT) && carrier_lost) begin
      zero_run_r <= 6'd0;
    end else if (hunt_bit_s) begin
      shift_r  <= shift_next_s[14:0];
      pre_ok_r <= {pre_ok_r[13:0], (zero_run_r >= PRE_MIN_C)};
      if (bit_in) begin
        zero_run_r <= 6'd0;
      end else if (zero_run_r != 6'd63) begin
        zero_run_r <= zero_run_r + 6'd1;
      end
    end
  end

  // Byte assembly, payload countdown and CRC-byte tracking; an abort drops
  // any partially received byte.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 3'd0;
      byte_sr_r  <= 7'd0;
      rem_r      <= 8'd0;
      crc_byte_r <= 1'b0;
    end else if (!in_frame_s || abort_s) begin
      bit_cnt_r  <= 3'd0;
      byte_sr_r  <= 7'd0;
      crc_byte_r <= 1'b0;
    end else if (rx_bit_s) begin
      bit_cnt_r <= bit_cnt_r + 3'd1;
      byte_sr_r <= byte_s[6:0];
      if (byte_done_s && (state_r == ST_LEN)) begin
        rem_r <= byte_s - 8'd1;
      end else if (byte_done_s && (state_r == ST_DATA)) begin
        rem_r <= rem_r - 8'd1;
      end else if (byte_done_s && (state_r == ST_CRC)) begin
        crc_byte_r <= 1'b1;
      end
    end
  end

  assign byte_data   = byte_data_r;
  assign byte_valid  = byte_valid_r;
  assign frame_start = frame_start_r;
  assign frame_end   = frame_end_r;
  assign crc_ok      = crc_ok_r;
  assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_felica_deframer.sv
// Directed self-checking bench for felica_deframer and felica_crc16.
module tb_felica_deframer;
  import felica_pkg::*;

`ifdef FELICA_DEFRAMER_CRC_CHECK_EN
  localparam logic BAD_CRC_OK = 1'b0;
`else
  localparam logic BAD_CRC_OK = 1'b1;
`endif

  logic       ck_1356meg = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       carrier_lost = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_start;
  logic       frame_end;
  logic       crc_ok;
  logic       frame_err;

  logic        crc_clr_t = 1'b0;
  logic        crc_en_t = 1'b0;
  logic        crc_bit_t = 1'b0;
  logic [15:0] crc_out_t;

  int checks = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         fs_cnt = 0;
  int         fe_cnt = 0;
  logic       last_ok = 1'b0;
  logic       last_err = 1'b0;

  logic [7:0] good_frame [8] = '{8'h06, 8'h01, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'hFD, 8'h07};
  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  always #10 ck_1356meg = ~ck_1356meg;

  felica_deframer dut (
    .ck_1356meg   (ck_1356meg),
    .rst_n        (rst_n),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .carrier_lost (carrier_lost),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .crc_ok       (crc_ok),
    .frame_err    (frame_err)
  );

  felica_crc16 u_crc_chk (
    .clk    (ck_1356meg),
    .rst_n  (rst_n),
    .clr    (crc_clr_t),
    .bit_en (crc_en_t),
    .bit_in (crc_bit_t),
    .crc    (crc_out_t)
  );

  // Output monitor, sampled on the rising edge (DUT changes on the falling edge).
  always @(posedge ck_1356meg) begin
    if (rst_n) begin
      if (byte_valid) rx_q.push_back(byte_data);
      if (frame_start) fs_cnt++;
      if (frame_end) begin
        fe_cnt++;
        last_ok  = crc_ok;
        last_err = frame_err;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(posedge ck_1356meg);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge ck_1356meg);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_hdr(input int nz);
    send_zeros(nz);
    send_byte(8'hB2);
    send_byte(8'h4D);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ck_1356meg);
  endtask

  task automatic clear_obs();
    rx_q.delete();
    fs_cnt   = 0;
    fe_cnt   = 0;
    last_ok  = 1'b0;
    last_err = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp [8]);
    logic [7:0] obs;
    check_val({tag, "_count"}, rx_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      obs = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check_val($sformatf("%s_byte%0d", tag, i), obs, exp[i]);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bad_frame [8];

    // Reset state.
    idle(3);
    check_val("reset_outputs",
              {byte_data, byte_valid, frame_start, frame_end, crc_ok, frame_err}, 13'd0);
    @(posedge ck_1356meg);
    rst_n = 1'b1;
    idle(2);

    // CRC engine check value over ASCII "123456789".
    @(posedge ck_1356meg);
    crc_clr_t = 1'b1;
    @(posedge ck_1356meg);
    crc_clr_t = 1'b0;
    for (int c = 0; c < 9; c++) begin
      for (int b = 7; b >= 0; b--) begin
        @(posedge ck_1356meg);
        crc_en_t  = 1'b1;
        crc_bit_t = msg[c][b];
      end
    end
    @(posedge ck_1356meg);
    crc_en_t = 1'b0;
    @(posedge ck_1356meg);
    check_val("crc16_check_value", crc_out_t, 16'h31C3);

    // Good frame with correct CRC 0xFD07.
    clear_obs();
    send_hdr(48);
    for (int i = 0; i < 8; i++) send_byte(good_frame[i]);
    idle(4);
    check_val("good_frame_start", fs_cnt, 1);
    check_bytes("good", good_frame);
    check_val("good_frame_end", fe_cnt, 1);
    check_val("good_crc_ok", last_ok, 1'b1);
    check_val("good_frame_err", last_err, 1'b0);

    // Same frame, bit 0 of the third payload byte flipped.
    bad_frame = good_frame;
    bad_frame[3] = 8'h0B;
    clear_obs();
    send_hdr(48);
    for (int i = 0; i < 8; i++) send_byte(bad_frame[i]);
    idle(4);
    check_bytes("badcrc", bad_frame);
    check_val("badcrc_frame_end", fe_cnt, 1);
    check_val("badcrc_crc_ok", last_ok, BAD_CRC_OK);
    check_val("badcrc_frame_err", last_err, 1'b0);

    // Short preamble must not sync; exactly PRE_MIN zeros must.
    clear_obs();
    send_hdr(8);
    idle(4);
    check_val("short_preamble_no_start", fs_cnt, 0);
    send_hdr(16);
    idle(2);
    check_val("min_preamble_start", fs_cnt, 1);

    // LEN 01 is too short: abort without byte strobes.
    send_byte(8'h01);
    idle(4);
    check_val("len01_frame_end", fe_cnt, 1);
    check_val("len01_frame_err", last_err, 1'b1);
    check_val("len01_crc_ok", last_ok, 1'b0);
    check_val("len01_no_bytes", rx_q.size(), 0);

    // LEN FF exceeds MAX_LEN.
    clear_obs();
    send_hdr(16);
    send_byte(8'hFF);
    idle(4);
    check_val("lenff_frame_start", fs_cnt, 1);
    check_val("lenff_frame_end", fe_cnt, 1);
    check_val("lenff_frame_err", last_err, 1'b1);
    check_val("lenff_no_bytes", rx_q.size(), 0);

    // Carrier lost after the third payload bit, coinciding with a bit strobe.
    clear_obs();
    send_hdr(48);
    send_byte(8'h06);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    @(posedge ck_1356meg);
    bit_valid    = 1'b1;
    bit_in       = 1'b1;
    carrier_lost = 1'b1;
    @(posedge ck_1356meg);
    bit_valid    = 1'b0;
    bit_in       = 1'b0;
    carrier_lost = 1'b0;
    check_val("carrier_frame_end_next", frame_end, 1'b1);
    check_val("carrier_frame_err", frame_err, 1'b1);
    check_val("carrier_crc_ok", crc_ok, 1'b0);
    idle(4);
    check_val("carrier_single_end", fe_cnt, 1);
    check_val("carrier_only_len_byte", rx_q.size(), 1);

    // Reset mid-DATA: outputs clear at once and no frame_end follows.
    clear_obs();
    send_hdr(48);
    send_byte(8'h06);
    send_byte(8'h01);
    send_bit(1'b0);
    send_bit(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("midreset_outputs",
              {byte_data, byte_valid, frame_start, frame_end, crc_ok, frame_err}, 13'd0);
    idle(3);
    rst_n = 1'b1;
    idle(40);
    check_val("midreset_no_frame_end", fe_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
